button_event_fsm: RTL and testbench
===================================

Name: button_event_fsm

Overview:
- Consumes the clean, debounced button level produced by the debounce stage.
- Converts that level into single-cycle event strobes for downstream control logic: press, click, long-press, auto-repeat and release.
- Adds a held status level.
- Sits between the debouncer output and the lab's mode/counter control FSMs.

Parameters:
LONG_COUNT, 100_000_000, cycles the button must stay held after press before long_press_pulse (~1 s @ 100 MHz); legal range >= 1
REPEAT_COUNT, 20_000_000, auto-repeat period in cycles once long-held (~200 ms @ 100 MHz); 0 disables repeat

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
btn_level  input  1  debounced button level, 1 = pressed, synchronous to clk
press_pulse  output  1  one-cycle strobe on press
click_pulse  output  1  one-cycle strobe on release before long-press threshold
long_press_pulse  output  1  one-cycle strobe when hold reaches LONG_COUNT
repeat_pulse  output  1  one-cycle strobe every REPEAT_COUNT cycles while long-held
release_pulse  output  1  one-cycle strobe on any release
held  output  1  level, 1 while state != IDLE

Behaviour:
- One clock: clk. Reset: asynchronous, active-low, on reset_n.
- Reset values:
  - State is IDLE; counter is 0.
  - All outputs are 0.
  - Reset mid-hold clears everything immediately and emits no release_pulse.
  - After reset deasserts with btn_level already 1, a press is detected on the first clock.
- All outputs are registered. Each strobe is high for exactly one cycle, in the cycle after the qualifying clock edge.
- Counter width: $clog2(max(LONG_COUNT, REPEAT_COUNT)), minimum 1. Counter never wraps; it is cleared on every state change and on every terminal hit.
- States:
  - IDLE:
    - btn_level=1: go to PRESSED, counter<=0, press_pulse<=1.
    - Otherwise stay.
  - PRESSED:
    - btn_level=0: go to IDLE, click_pulse<=1 and release_pulse<=1 in the same cycle.
    - btn_level=1 and counter==LONG_COUNT-1: go to LONG_HELD, counter<=0, long_press_pulse<=1.
    - Otherwise counter++.
  - LONG_HELD:
    - btn_level=0: go to IDLE, release_pulse<=1, no click_pulse.
    - btn_level=1, REPEAT_COUNT>0 and counter==REPEAT_COUNT-1: repeat_pulse<=1, counter<=0.
    - Otherwise counter++ (counter held at 0 when REPEAT_COUNT==0).
- Timing:
  - long_press_pulse rises exactly LONG_COUNT cycles after press_pulse, given a continuous hold.
  - The first repeat_pulse rises REPEAT_COUNT cycles after long_press_pulse, then every REPEAT_COUNT cycles.
- Simultaneous events:
  - Release on the same edge the counter is at terminal: release wins; no long_press_pulse or repeat_pulse.
  - press_pulse, long_press_pulse and repeat_pulse are mutually exclusive in any cycle.
  - click_pulse occurs only together with release_pulse.
- held:
  - Rises in the same cycle as press_pulse.
  - Falls in the same cycle as release_pulse.
- Minimal activity:
  - A 1-cycle press (level high for one sample) yields press_pulse, then the next cycle click_pulse + release_pulse.
  - Back-to-back press is legal: IDLE re-enters PRESSED on the edge after release if btn_level=1.
- btn_level is assumed already synchronous; no internal synchronizer or debounce.

Test Plan:
- Short click (LONG_COUNT=8, REPEAT_COUNT=4): reset, btn_level high 3 cycles then low -> press_pulse at cycle 1; click_pulse + release_pulse one cycle after low sampled; no long or repeat; held high 3 cycles.
- Long hold with repeat (LONG_COUNT=8, REPEAT_COUNT=4): hold 30 cycles -> long_press_pulse 8 cycles after press_pulse; repeat_pulse at +4, +8, +12, +16, +20 after it; on release, release_pulse only, no click_pulse.
- Boundary release: release sampled on the edge where counter==7 in PRESSED -> click_pulse + release_pulse; long_press_pulse never asserts.
- Repeat disabled (REPEAT_COUNT=0, LONG_COUNT=8): hold 40 cycles -> exactly one long_press_pulse, zero repeat_pulse, held stays 1.
- Reset mid-hold: assert reset_n=0 for 2 cycles while in LONG_HELD -> all outputs 0 immediately, no release_pulse; btn_level still 1 at deassert -> press_pulse on first clock after.
- Degenerate LONG_COUNT=1: 2-cycle press -> press_pulse, then long_press_pulse next cycle, then release_pulse; one-cycle press -> click_pulse + release_pulse, no long_press_pulse.

Source files
------------

// File: rtl/button_event_fsm.sv
// Turns a debounced button level into press/click/long-press/repeat/release strobes
// plus a held level for the mode and counter control logic.
module button_event_fsm #(
    parameter int unsigned LONG_COUNT   = 32'd100_000_000,
    parameter int unsigned REPEAT_COUNT = 32'd20_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_level,
    output logic press_pulse,
    output logic click_pulse,
    output logic long_press_pulse,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    localparam int unsigned MAX_COUNT = (LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT;
    localparam int unsigned CNT_W     = (MAX_COUNT > 32'd1) ? $clog2(MAX_COUNT) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_COUNT - 32'd1);
    // With repeat disabled the terminal value is never consulted.
    localparam logic [CNT_W-1:0] REPEAT_TERM = (REPEAT_COUNT > 32'd0) ? CNT_W'(REPEAT_COUNT - 32'd1) : CNT_ZERO;
    localparam logic             REPEAT_EN   = (REPEAT_COUNT != 32'd0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             press_s;
    logic             click_s;
    logic             long_s;
    logic             repeat_s;
    logic             release_s;

    // Next-state, counter and strobe decode; release always takes priority over terminal hits.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        press_s   = 1'b0;
        click_s   = 1'b0;
        long_s    = 1'b0;
        repeat_s  = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_level) begin
                    state_s = PRESSED;
                    cnt_s   = CNT_ZERO;
                    press_s = 1'b1;
                end else begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            PRESSED: begin
                if (!btn_level) begin
                    state_s   = IDLE;
                    cnt_s     = CNT_ZERO;
                    click_s   = 1'b1;
                    release_s = 1'b1;
                end else if (cnt_r == LONG_TERM) begin
                    state_s = LONG_HELD;
                    cnt_s   = CNT_ZERO;
                    long_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (!btn_level) begin
                    state_s   = IDLE;
                    cnt_s     = CNT_ZERO;
                    release_s = 1'b1;
                end else if (REPEAT_EN && (cnt_r == REPEAT_TERM)) begin
                    cnt_s    = CNT_ZERO;
                    repeat_s = 1'b1;
                end else if (REPEAT_EN) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs; held tracks the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= IDLE;
            cnt_r            <= CNT_ZERO;
            press_pulse      <= 1'b0;
            click_pulse      <= 1'b0;
            long_press_pulse <= 1'b0;
            repeat_pulse     <= 1'b0;
            release_pulse    <= 1'b0;
            held             <= 1'b0;
        end else begin
            state_r          <= state_s;
            cnt_r            <= cnt_s;
            press_pulse      <= press_s;
            click_pulse      <= click_s;
            long_press_pulse <= long_s;
            repeat_pulse     <= repeat_s;
            release_pulse    <= release_s;
            held             <= (state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_button_event_fsm.sv
// Checks three button_event_fsm configurations against a hold-age reference model
// using directed steps followed by randomized button activity.
module tb_button_event_fsm;

    logic clk;
    logic reset_n;
    logic btn [3];
    logic pr [3];
    logic cl [3];
    logic lp [3];
    logic rp [3];
    logic rl [3];
    logic hd [3];

    int   total = 0;
    int   bad   = 0;

    // reference model: hold age in cycles since the press edge
    int         lc [3] = '{8, 8, 1};
    int         rc [3] = '{4, 0, 4};
    bit         m_active [3];
    int         m_age [3];
    logic [5:0] exp_v [3];

    button_event_fsm #(.LONG_COUNT(8), .REPEAT_COUNT(4)) u_a (
        .clk(clk), .reset_n(reset_n), .btn_level(btn[0]),
        .press_pulse(pr[0]), .click_pulse(cl[0]), .long_press_pulse(lp[0]),
        .repeat_pulse(rp[0]), .release_pulse(rl[0]), .held(hd[0]));

    button_event_fsm #(.LONG_COUNT(8), .REPEAT_COUNT(0)) u_b (
        .clk(clk), .reset_n(reset_n), .btn_level(btn[1]),
        .press_pulse(pr[1]), .click_pulse(cl[1]), .long_press_pulse(lp[1]),
        .repeat_pulse(rp[1]), .release_pulse(rl[1]), .held(hd[1]));

    button_event_fsm #(.LONG_COUNT(1), .REPEAT_COUNT(4)) u_c (
        .clk(clk), .reset_n(reset_n), .btn_level(btn[2]),
        .press_pulse(pr[2]), .click_pulse(cl[2]), .long_press_pulse(lp[2]),
        .repeat_pulse(rp[2]), .release_pulse(rl[2]), .held(hd[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_active[i] = 1'b0;
            m_age[i]    = 0;
            exp_v[i]    = 6'b000000;
        end
    endtask

    // expected {press, click, long, repeat, release, held} after one edge
    task automatic model_step(input int i, input bit b);
        bit p, c, l, r, rel;
        p = 1'b0; c = 1'b0; l = 1'b0; r = 1'b0; rel = 1'b0;
        if (!m_active[i]) begin
            if (b) begin
                p           = 1'b1;
                m_active[i] = 1'b1;
                m_age[i]    = 0;
            end
        end else begin
            m_age[i] = m_age[i] + 1;
            if (!b) begin
                rel         = 1'b1;
                c           = (m_age[i] <= lc[i]);
                m_active[i] = 1'b0;
            end else if (m_age[i] == lc[i]) begin
                l = 1'b1;
            end else if (rc[i] > 0 && m_age[i] > lc[i] && ((m_age[i] - lc[i]) % rc[i]) == 0) begin
                r = 1'b1;
            end
        end
        exp_v[i] = {p, c, l, r, rel, m_active[i]};
    endtask

    task automatic check_all(input string phase);
        for (int i = 0; i < 3; i++) begin
            logic [5:0] obs;
            obs   = {pr[i], cl[i], lp[i], rp[i], rl[i], hd[i]};
            total = total + 1;
            assert (obs === exp_v[i]) else begin
                bad = bad + 1;
                $error("FAIL %s inst%0d t=%0t: observed=%b expected=%b (press,click,long,rep,rel,held)",
                       phase, i, $time, obs, exp_v[i]);
            end
        end
    endtask

    task automatic tick(input string phase);
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) model_step(i, btn[i]);
        end
        #1;
        check_all(phase);
    endtask

    task automatic run(input bit v, input int n, input string phase);
        for (int i = 0; i < 3; i++) btn[i] = v;
        repeat (n) tick(phase);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) btn[i] = 1'b0;
        model_reset();
        #1;
        check_all("reset_t0");
        repeat (3) tick("reset");
        reset_n = 1'b1;

        run(1'b0, 2,  "idle");
        run(1'b1, 3,  "short_hold");
        run(1'b0, 4,  "short_rel");
        run(1'b1, 30, "long_hold");
        run(1'b0, 3,  "long_rel");
        run(1'b1, 8,  "boundary_hold");
        run(1'b0, 3,  "boundary_rel");
        run(1'b1, 40, "norep_hold");
        run(1'b0, 3,  "norep_rel");
        run(1'b1, 20, "midhold");

        // asynchronous reset between edges while long-held
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        repeat (2) tick("in_rst");
        reset_n = 1'b1;
        run(1'b1, 5,  "post_rst");
        run(1'b0, 3,  "post_rst_rel");

        run(1'b1, 2,  "two_cycle");
        run(1'b0, 2,  "two_cycle_rel");
        run(1'b1, 1,  "one_cycle");
        run(1'b0, 3,  "one_cycle_rel");
        run(1'b1, 1,  "b2b_a");
        run(1'b0, 1,  "b2b_rel");
        run(1'b1, 1,  "b2b_b");
        run(1'b0, 2,  "b2b_end");

        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
            end
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
